// File: rtl/axis_trigger_scope.sv
// axis_trigger_scope: AXI-Stream capture gate with pre-trigger depth and internal level/edge trigger.
// Latency: zero; tdata/tvalid/tlast are combinational from the slave side, status outputs are registered.
// Backpressure: s_axis_tready mirrors m_axis_tready; beats outside a run are accepted and dropped.
//
// Ports:
//   aclk / aresetn         clock, synchronous active-low reset
//   run_flag               start a run (sampled only while idle)
//   ext_trg_flag           external trigger, rising edge detected internally
//   trg_mode               00 external, 01 rising level, 10 falling level, 11 force
//   trg_chan / trg_level   trigger channel select (out-of-range -> ch0) and signed threshold
//   pre_data / tot_data    pre-trigger beats and total beats per record
//   sts_data               {trg_addr, running}; complete = !running; triggered = trigger seen this run
//   s_axis_* / m_axis_*    input sample stream and gated output stream
// Build option: define AXIS_TRIGGER_SCOPE_DECIM_EN to add input decim[15:0]; only every
// (decim+1)-th accepted beat is forwarded, counted and trigger-evaluated.
module axis_trigger_scope #(
    parameter int CHANNELS         = 2,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 12
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           run_flag,
    input  logic                           ext_trg_flag,
    input  logic [1:0]                     trg_mode,
    input  logic [7:0]                     trg_chan,
    input  logic signed [SAMPLE_WIDTH-1:0] trg_level,
    input  logic [CNTR_WIDTH-1:0]          pre_data,
    input  logic [CNTR_WIDTH-1:0]          tot_data,
`ifdef AXIS_TRIGGER_SCOPE_DECIM_EN
    input  logic [15:0]                    decim,
`endif
    output logic [CNTR_WIDTH:0]            sts_data,
    output logic                           complete,
    output logic                           triggered,
    input  logic [AXIS_TDATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]    m_axis_tdata,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    input  logic                           m_axis_tready
);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_ARMED, S_POST} state_t;

    localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);

    state_t                          state_q;
    logic [CNTR_WIDTH-1:0]           addr_q;
    logic [CNTR_WIDTH-1:0]           cnt_q;
    logic [CNTR_WIDTH-1:0]           trg_addr_q;
    logic                            triggered_q;
    logic signed [SAMPLE_WIDTH-1:0]  prev_q;
    logic                            prev_vld_q;
    logic                            ext_prev_q;
    logic                            pend_q;

    logic                            running;
    logic                            beat;
    logic                            dec_hit;
    logic                            cbeat;
    logic                            ext_edge;
    logic signed [SAMPLE_WIDTH-1:0]  cur_sample;
    logic                            lvl_rise;
    logic                            lvl_fall;
    logic                            hit_sel;
    logic [CNTR_WIDTH-1:0]           post_len;
    logic [CNTR_WIDTH-1:0]           post_last;
    logic                            last_cond;
    logic [CNTR_WIDTH-1:0]           addr_d;

`ifdef AXIS_TRIGGER_SCOPE_DECIM_EN
    logic [15:0] dec_cnt_q;
    assign dec_hit = (dec_cnt_q == 16'd0);
`else
    assign dec_hit = 1'b1;
`endif

    assign running       = (state_q != S_IDLE);
    assign beat          = s_axis_tvalid & m_axis_tready;
    assign cbeat         = beat & running & dec_hit;
    assign ext_edge      = ext_trg_flag & ~ext_prev_q;
    assign addr_d        = addr_q + ONE;

    assign s_axis_tready = m_axis_tready;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = s_axis_tvalid & running & dec_hit;

    assign sts_data      = {trg_addr_q, running};
    assign complete      = ~running;
    assign triggered     = triggered_q;

    // Out-of-range channel indices fall back to channel 0.
    always_comb begin
        cur_sample = s_axis_tdata[SAMPLE_WIDTH-1:0];
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(trg_chan) == k) begin
                cur_sample = s_axis_tdata[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
        end
    end

    // Level crossings need a previous sample from this run, so the first beat never fires.
    assign lvl_rise = prev_vld_q && (prev_q < trg_level) && (cur_sample >= trg_level);
    assign lvl_fall = prev_vld_q && (prev_q > trg_level) && (cur_sample <= trg_level);

    always_comb begin
        case (trg_mode)
            2'b00:   hit_sel = pend_q | ext_edge;
            2'b01:   hit_sel = lvl_rise;
            2'b10:   hit_sel = lvl_fall;
            default: hit_sel = 1'b1;
        endcase
    end

    // Post-trigger length includes the trigger beat; a non-positive length collapses to one beat.
    assign post_len  = (tot_data > pre_data) ? (tot_data - pre_data) : ONE;
    assign post_last = post_len - ONE;

    // tlast is qualified by tvalid only, so it does not depend combinationally on tready.
    assign last_cond = ((state_q == S_POST) && (cnt_q == post_last)) ||
                       ((state_q == S_ARMED) && hit_sel && (post_len == ONE));
    assign m_axis_tlast = m_axis_tvalid & last_cond;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            trg_addr_q  <= '0;
            triggered_q <= 1'b0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            ext_prev_q  <= 1'b0;
            pend_q      <= 1'b0;
`ifdef AXIS_TRIGGER_SCOPE_DECIM_EN
            dec_cnt_q   <= '0;
`endif
        end else begin
            ext_prev_q <= ext_trg_flag;

`ifdef AXIS_TRIGGER_SCOPE_DECIM_EN
            if (beat && running) begin
                dec_cnt_q <= (dec_cnt_q >= decim) ? 16'd0 : dec_cnt_q + 16'd1;
            end
`endif

            if (cbeat) begin
                addr_q     <= addr_d;
                prev_q     <= cur_sample;
                prev_vld_q <= 1'b1;
            end

            // External edges only count while armed.
            if (state_q != S_ARMED) begin
                pend_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (run_flag) begin
                        state_q     <= S_PRE;
                        addr_q      <= '0;
                        cnt_q       <= '0;
                        trg_addr_q  <= '0;
                        triggered_q <= 1'b0;
                        prev_q      <= '0;
                        prev_vld_q  <= 1'b0;
`ifdef AXIS_TRIGGER_SCOPE_DECIM_EN
                        dec_cnt_q   <= '0;
`endif
                    end
                end
                S_PRE: begin
                    if (pre_data == '0) begin
                        state_q <= S_ARMED;
                    end else if (cbeat) begin
                        cnt_q <= cnt_q + ONE;
                        if (cnt_q == pre_data - ONE) begin
                            state_q <= S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (cbeat) begin
                        pend_q <= 1'b0;
                        if (hit_sel) begin
                            trg_addr_q  <= addr_q;
                            triggered_q <= 1'b1;
                            cnt_q       <= ONE;
                            state_q     <= (post_len == ONE) ? S_IDLE : S_POST;
                        end
                    end else if (ext_edge) begin
                        pend_q <= 1'b1;
                    end
                end
                S_POST: begin
                    if (cbeat) begin
                        if (cnt_q == post_last) begin
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
